// File: rtl/lift_pkg.sv
// Shared definitions for the dual-lift request dispatcher: default sizes,
// dispatcher FSM states and the floor distance helper.
package lift_pkg;

    localparam int LIFT_FLOORS = 16;
    localparam int LIFT_FW     = 4;
    localparam int LIFT_CNTW   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    // Absolute floor distance; operands are zero-extended floor codes, so
    // the subtraction never wraps.
    function automatic int unsigned floor_dist(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/lift_pending_mask.sv
// Pending-floor mask for one lift. A floor bit is set when the dispatcher
// writes that floor into the lift FIFO and cleared when the lift reports it
// served the floor. If both hit the same bit in one cycle, the set wins so a
// freshly queued request is never lost.
module lift_pending_mask
    import lift_pkg::*;
#(
    parameter int FLOORS = LIFT_FLOORS,
    parameter int FW     = LIFT_FW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_i,
    input  logic [FW-1:0]     set_floor_i,
    input  logic              clr_i,
    input  logic [FW-1:0]     clr_floor_i,
    output logic [FLOORS-1:0] mask_o
);

    logic [FLOORS-1:0] mask_q, mask_d;
    logic [FLOORS-1:0] set_vec, clr_vec;

    // Decode set/clear floors into one-hot vectors; out-of-range codes decode to nothing.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 0; i < FLOORS; i++) begin
            set_vec[i] = set_i && (32'(set_floor_i) == 32'(i));
            clr_vec[i] = clr_i && (32'(clr_floor_i) == 32'(i));
        end
        mask_d = (mask_q & ~clr_vec) | set_vec;
    end

    // Mask register.
    always_ff @(posedge clk) begin
        if (rst) mask_q <= '0;
        else     mask_q <= mask_d;
    end

    assign mask_o = mask_q;

endmodule

// File: rtl/lift_dispatcher.sv
// Dual-lift request dispatcher. Accepts one floor request at a time, drops
// invalid floors and floors already pending on either lift, and writes each
// accepted floor into the FIFO of the nearer lift (round-robin on ties,
// falling back to the other lift if the preferred FIFO is full, waiting if
// both are full).
module lift_dispatcher
    import lift_pkg::*;
#(
    parameter int FLOORS = LIFT_FLOORS,
    parameter int FW     = LIFT_FW,
    parameter int CNTW   = LIFT_CNTW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [FW-1:0]     req_floor,
    output logic              req_ready,
    input  logic [FW-1:0]     floor_l1,
    input  logic [FW-1:0]     floor_l2,
    input  logic              full1,
    input  logic              full2,
    input  logic              arr1_valid,
    input  logic [FW-1:0]     arr1_floor,
    input  logic              arr2_valid,
    input  logic [FW-1:0]     arr2_floor,
    output logic              wr1,
    output logic              wr2,
    output logic [FW-1:0]     din1,
    output logic [FW-1:0]     din2,
    output logic [FLOORS-1:0] pend1,
    output logic [FLOORS-1:0] pend2,
    output logic [CNTW-1:0]   drop_cnt
);

    state_e          state_q, state_d;
    logic [FW-1:0]   req_q, req_d;
    logic            sel_q, sel_d;     // 0 = lift 1, 1 = lift 2
    logic            rr_q, rr_d;       // tie-break pointer, 0 = lift 1
    logic [FW-1:0]   din1_q, din1_d;
    logic [FW-1:0]   din2_q, din2_d;
    logic [CNTW-1:0] drop_q, drop_d;

    logic            invalid, hit1, hit2;
    int unsigned     d1, d2;
    logic            tie, pref, pref_full, other_full;

    // Lookup of the held request in the registered pending masks.
    always_comb begin
        invalid = (32'(req_q) >= 32'(FLOORS));
        hit1    = 1'b0;
        hit2    = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (32'(req_q) == 32'(i)) begin
                hit1 = pend1[i];
                hit2 = pend2[i];
            end
        end
    end

    // Lift preference: smaller distance wins, rr pointer breaks ties.
    always_comb begin
        d1         = floor_dist(32'(req_q), 32'(floor_l1));
        d2         = floor_dist(32'(req_q), 32'(floor_l2));
        tie        = (d1 == d2);
        pref       = tie ? rr_q : (d2 < d1);
        pref_full  = pref ? full2 : full1;
        other_full = pref ? full1 : full2;
    end

    // Next-state logic for the dispatcher FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        din1_d  = din1_q;
        din2_d  = din2_q;
        drop_d  = drop_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d   = req_floor;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (invalid || hit1 || hit2) begin
                    if (drop_q != {CNTW{1'b1}}) drop_d = drop_q + 1'b1;
                    state_d = ST_IDLE;
                end else if (pref_full && other_full) begin
                    state_d = ST_WAIT;
                end else begin
                    // Write data is staged here so din changes only with its strobe.
                    sel_d = pref_full ? ~pref : pref;
                    if (sel_d) din2_d = req_q;
                    else       din1_d = req_q;
                    if (tie) rr_d = ~rr_q;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (!full1 || !full2) state_d = ST_EVAL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
            din1_q  <= '0;
            din2_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            din1_q  <= din1_d;
            din2_q  <= din2_d;
            drop_q  <= drop_d;
        end
    end

    lift_pending_mask #(.FLOORS(FLOORS), .FW(FW)) u_pend1 (
        .clk        (clk),
        .rst        (rst),
        .set_i      (wr1),
        .set_floor_i(req_q),
        .clr_i      (arr1_valid),
        .clr_floor_i(arr1_floor),
        .mask_o     (pend1)
    );

    lift_pending_mask #(.FLOORS(FLOORS), .FW(FW)) u_pend2 (
        .clk        (clk),
        .rst        (rst),
        .set_i      (wr2),
        .set_floor_i(req_q),
        .clr_i      (arr2_valid),
        .clr_floor_i(arr2_floor),
        .mask_o     (pend2)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign wr1       = (state_q == ST_ISSUE) && !sel_q;
    assign wr2       = (state_q == ST_ISSUE) &&  sel_q;
    assign din1      = din1_q;
    assign din2      = din2_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_lift_dispatcher.sv
// Self-checking bench for lift_dispatcher: a behavioural model tracks what
// each output must be from the dispatch rules and is compared every cycle;
// directed scenarios add literal expectations at key cycles.
module tb_lift_dispatcher;

    localparam int FLOORS = 12;
    localparam int FW     = 5;
    localparam int CNTW   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic [FW-1:0]     req_floor = '0;
    logic [FW-1:0]     floor_l1 = '0;
    logic [FW-1:0]     floor_l2 = '0;
    logic              full1 = 1'b0;
    logic              full2 = 1'b0;
    logic              arr1_valid = 1'b0;
    logic [FW-1:0]     arr1_floor = '0;
    logic              arr2_valid = 1'b0;
    logic [FW-1:0]     arr2_floor = '0;
    logic              req_ready, wr1, wr2;
    logic [FW-1:0]     din1, din2;
    logic [FLOORS-1:0] pend1, pend2;
    logic [CNTW-1:0]   drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lift_dispatcher #(.FLOORS(FLOORS), .FW(FW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_floor(req_floor), .req_ready(req_ready),
        .floor_l1(floor_l1), .floor_l2(floor_l2),
        .full1(full1), .full2(full2),
        .arr1_valid(arr1_valid), .arr1_floor(arr1_floor),
        .arr2_valid(arr2_valid), .arr2_floor(arr2_floor),
        .wr1(wr1), .wr2(wr2), .din1(din1), .din2(din2),
        .pend1(pend1), .pend2(pend2), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 free, 1 deciding, 2 writing to m_lift, 3 blocked on full FIFOs
    int m_phase = 0;
    int m_req   = 0;
    int m_lift  = 1;
    int m_rr    = 1;   // lift that wins the next tie
    int m_din1  = 0;
    int m_din2  = 0;
    int m_drop  = 0;
    bit m_p1[FLOORS];
    bit m_p2[FLOORS];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step();
        bit set_now;
        int set_lift, pref, other, choice, dd1, dd2;
        bit pf, of;
        set_now = 0; set_lift = 0;
        if (rst) begin
            m_phase = 0; m_rr = 1; m_din1 = 0; m_din2 = 0; m_drop = 0;
            foreach (m_p1[i]) begin m_p1[i] = 0; m_p2[i] = 0; end
            return;
        end
        case (m_phase)
            0: if (req_valid) begin m_req = int'(req_floor); m_phase = 1; end
            1: begin
                if (m_req >= FLOORS || m_p1[m_req] || m_p2[m_req]) begin
                    if (m_drop < (1 << CNTW) - 1) m_drop++;
                    m_phase = 0;
                end else begin
                    dd1 = iabs(m_req - int'(floor_l1));
                    dd2 = iabs(m_req - int'(floor_l2));
                    pref  = (dd1 < dd2) ? 1 : (dd2 < dd1) ? 2 : m_rr;
                    other = 3 - pref;
                    pf = (pref == 1) ? full1 : full2;
                    of = (other == 1) ? full1 : full2;
                    choice = !pf ? pref : (!of ? other : 0);
                    if (choice == 0) m_phase = 3;
                    else begin
                        if (dd1 == dd2) m_rr = 3 - m_rr;
                        m_lift = choice;
                        if (choice == 1) m_din1 = m_req; else m_din2 = m_req;
                        m_phase = 2;
                    end
                end
            end
            2: begin set_now = 1; set_lift = m_lift; m_phase = 0; end
            3: if (!full1 || !full2) m_phase = 1;
            default: m_phase = 0;
        endcase
        if (arr1_valid && int'(arr1_floor) < FLOORS) m_p1[int'(arr1_floor)] = 0;
        if (arr2_valid && int'(arr2_floor) < FLOORS) m_p2[int'(arr2_floor)] = 0;
        if (set_now) begin
            if (set_lift == 1) m_p1[m_req] = 1; else m_p2[m_req] = 1;
        end
    endtask

    task automatic compare_all();
        logic [FLOORS-1:0] e1, e2;
        foreach (m_p1[i]) begin e1[i] = m_p1[i]; e2[i] = m_p2[i]; end
        chk("cyc_req_ready", 32'(req_ready), 32'(m_phase == 0));
        chk("cyc_wr1", 32'(wr1), 32'(m_phase == 2 && m_lift == 1));
        chk("cyc_wr2", 32'(wr2), 32'(m_phase == 2 && m_lift == 2));
        chk("cyc_din1", 32'(din1), 32'(m_din1));
        chk("cyc_din2", 32'(din2), 32'(m_din2));
        chk("cyc_pend1", 32'(pend1), 32'(e1));
        chk("cyc_pend2", 32'(pend2), 32'(e2));
        chk("cyc_drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    // Single compare process: model advances on each edge, outputs checked mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int f);
        int n;
        n = 0;
        while (!req_ready && n < 30) begin tick(); n++; end
        if (!req_ready) chk("send_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_floor = FW'(f);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_wr", 32'({wr1, wr2}), 32'd0);
        chk("rst_din", 32'({din1, din2}), 32'd0);
        chk("rst_pend", 32'({pend1, pend2}), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // nearer lift: l1=0, l2=9, floor 3 -> lift 1
        floor_l1 = 5'd0; floor_l2 = 5'd9;
        send(3);
        chk("t1_eval_no_wr", 32'({wr1, wr2}), 32'd0);
        tick();
        chk("t1_wr1", 32'(wr1), 32'd1);
        chk("t1_din1", 32'(din1), 32'd3);
        chk("t1_wr2", 32'(wr2), 32'd0);
        tick();
        chk("t1_pend1", 32'(pend1), 32'h008);
        chk("t1_ready", 32'(req_ready), 32'd1);

        // ties: first to lift 1, next to lift 2
        floor_l1 = 5'd2; floor_l2 = 5'd6;
        send(4); tick();
        chk("t2_tie1_wr1", 32'(wr1), 32'd1);
        chk("t2_tie1_din1", 32'(din1), 32'd4);
        tick();
        arr1_valid = 1'b1; arr1_floor = 5'd4; tick(); arr1_valid = 1'b0;
        chk("t2_arr_clear", 32'(pend1), 32'h008);
        send(4); tick();
        chk("t2_tie2_wr2", 32'(wr2), 32'd1);
        chk("t2_tie2_wr1", 32'(wr1), 32'd0);
        chk("t2_tie2_din2", 32'(din2), 32'd4);
        tick();

        // duplicates and invalid floors are dropped
        send(3); tick();
        chk("t3_dup_ready", 32'(req_ready), 32'd1);
        chk("t3_dup_drop", 32'(drop_cnt), 32'd1);
        chk("t3_dup_nowr", 32'({wr1, wr2}), 32'd0);
        send(20); tick();
        chk("t3_inv20_drop", 32'(drop_cnt), 32'd2);
        send(12); tick();
        chk("t3_inv12_drop", 32'(drop_cnt), 32'd3);
        send(11); tick();
        chk("t3_top_wr2", 32'(wr2), 32'd1);
        chk("t3_top_din2", 32'(din2), 32'd11);
        tick();

        // full fallback and wait
        floor_l1 = 5'd0; floor_l2 = 5'd9; full1 = 1'b1;
        send(1); tick();
        chk("t4_fallback_wr2", 32'(wr2), 32'd1);
        chk("t4_fallback_din2", 32'(din2), 32'd1);
        tick();
        full2 = 1'b1;
        send(7); tick();
        chk("t4_wait_ready", 32'(req_ready), 32'd0);
        tick(); tick();
        chk("t4_wait_nowr", 32'({wr1, wr2}), 32'd0);
        full2 = 1'b0;
        tick();
        chk("t4_reeval_nowr", 32'({wr1, wr2}), 32'd0);
        tick();
        chk("t4_release_wr2", 32'(wr2), 32'd1);
        chk("t4_release_din2", 32'(din2), 32'd7);
        full1 = 1'b0;
        tick();

        // arrival clears; arrival coinciding with the write loses to the set
        arr1_valid = 1'b1; arr1_floor = 5'd3; tick(); arr1_valid = 1'b0;
        chk("t5_arr_clear3", 32'(pend1[3]), 32'd0);
        send(3); tick();
        chk("t5_reaccept_wr1", 32'(wr1), 32'd1);
        arr1_valid = 1'b1; arr1_floor = 5'd3; tick(); arr1_valid = 1'b0;
        chk("t5_set_wins", 32'(pend1[3]), 32'd1);

        // reset while blocked in WAIT
        full1 = 1'b1; full2 = 1'b1;
        send(5); tick(); tick();
        chk("t6_in_wait", 32'(req_ready), 32'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_ready", 32'(req_ready), 32'd1);
        chk("t6_rst_pend", 32'({pend1, pend2}), 32'd0);
        chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
        chk("t6_rst_wr", 32'({wr1, wr2}), 32'd0);
        full1 = 1'b0; full2 = 1'b0;
        tick(); tick(); tick();
        chk("t6_no_late_wr", 32'({wr1, wr2}), 32'd0);

        // drop counter saturates
        for (int i = 0; i < 260; i++) send(20);
        tick();
        chk("t7_drop_sat", 32'(drop_cnt), 32'd255);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
